mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, as the operand and HI/LO width in bits.
REQ-002 The block SHALL have parameter MUL_CYCLES, default 5, as the busy cycles for MULT/MULTU (legal range 1..255).
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, as the busy cycles for DIV/DIVU (legal range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit, as the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, as the reset: asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit, as a request to launch op; sampled on the rising edge.
REQ-007 The block SHALL have port op, input, 3 bits, as the operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-008 The block SHALL have port a, input, WIDTH bits, as operand A (dividend / multiplicand / MTHI-MTLO data).
REQ-009 The block SHALL have port b, input, WIDTH bits, as operand B (divisor / multiplier).
REQ-010 The block SHALL have port busy, output, 1 bit, high while an arithmetic operation is in flight.
REQ-011 The block SHALL have port done, output, 1 bit, as a one-cycle pulse in the cycle HI/LO take an arithmetic result.
REQ-012 The block SHALL have port hi, output, WIDTH bits, as the registered HI value.
REQ-013 The block SHALL have port lo, output, WIDTH bits, as the registered LO value.

Function
REQ-014 The FSM SHALL have states IDLE, MUL and DIV, plus a down-counter of 8 bits.
REQ-015 In IDLE with start=1 and op MULT/MULTU/DIV/DIVU, the block SHALL latch a, b and op, load the counter with MUL_CYCLES or DIV_CYCLES, enter MUL/DIV and assert busy from the next cycle.
REQ-016 In MUL/DIV, the counter SHALL decrement each cycle; on the edge where it reaches zero, hi/lo SHALL update, busy SHALL drop, done SHALL pulse for exactly one cycle and the state SHALL return to IDLE.
REQ-017 Total latency SHALL be exactly N cycles (MUL_CYCLES or DIV_CYCLES) of busy=1 between the start edge and the result edge.
REQ-018 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo on that edge, with no busy and no done.
REQ-019 start while busy=1 SHALL be ignored, with no latch and no effect on the in-flight operation.
REQ-020 start with a reserved op SHALL be ignored.
REQ-021 MULT SHALL compute the signed 2*WIDTH product, and MULTU the unsigned product; hi SHALL take the upper WIDTH bits and lo the lower WIDTH bits.
REQ-022 DIV SHALL compute a signed quotient truncated toward zero into lo and the remainder into hi, with the remainder taking the dividend's sign.
REQ-023 DIVU SHALL compute the unsigned quotient into lo and the remainder into hi.
REQ-024 A divisor of 0 SHALL leave hi/lo unchanged; busy and done SHALL still behave per REQ-016.
REQ-025 Signed overflow (a=most-negative, b=-1) SHALL yield lo=most-negative and hi=0.
REQ-026 Operands SHALL be sampled only at launch; later changes on a/b/op SHALL NOT affect the result.
REQ-027 The block SHALL accept a new start in the cycle after done (back-to-back issue).

Reset
REQ-028 Asserting reset (low) SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, hi=0 and lo=0.
REQ-029 Reset mid-operation SHALL abort the operation with no result written, and no done after release.
REQ-030 After reset deasserts, the first rising edge SHALL accept start normally.

Structure
REQ-031 Op-code constants (MDU_MULT..MDU_MTLO) and the FSM state encoding SHALL live in the shared package mdu_pkg.
REQ-032 Arithmetic SHALL be a single combinational sub-module, mdu_arith (inputs a, b and op; outputs hi_res and lo_res), and mdu_unit SHALL own only the FSM, counter and registers.
REQ-033 The result SHALL be registered only at completion; hi/lo outputs SHALL be driven directly from registers.

Verification
REQ-034 The bench SHALL check: MULT a=0xFFFFFFFE, b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for 1 cycle.
REQ-035 The bench SHALL check: DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-036 The bench SHALL check: MTHI a=0x12345678, then DIVU b=0 -> hi stays 0x12345678, lo unchanged, done pulses after 10 cycles.
REQ-037 The bench SHALL check: MULTU 0x10000*0x10000 with start re-asserted (MTLO 0xAA) at cycle 2 -> MTLO ignored, hi=1, lo=0.
REQ-038 The bench SHALL check: reset pulled low at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately, and no done after release.
REQ-039 The bench SHALL check: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; a following MULT issued the cycle after done is accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op-codes, FSM states, counter width.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational MULT/MULTU/DIV/DIVU datapath producing the HI/LO pair.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    logic signed [2*WIDTH-1:0] sprod;
    logic        [2*WIDTH-1:0] uprod;
    logic                      a_neg, b_neg;
    logic        [WIDTH-1:0]   a_mag, b_mag, div_b;
    logic        [WIDTH-1:0]   q_mag, r_mag, sq, sr;
    logic        [WIDTH-1:0]   uq, ur, div_bu;

    assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide via magnitudes; most-negative / -1 wraps naturally to most-negative, rem 0.
    assign a_neg  = a[WIDTH-1];
    assign b_neg  = b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    // A zero divisor is swapped for 1 so the datapath never divides by zero; the unit discards it.
    assign div_b  = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag  = a_mag / div_b;
    assign r_mag  = a_mag % div_b;
    assign sq     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign sr     = a_neg ? -r_mag : r_mag;

    assign div_bu = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign uq     = a / div_bu;
    assign ur     = a % div_bu;

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        case (op)
            MDU_MULT: begin
                hi_res = sprod[2*WIDTH-1:WIDTH];
                lo_res = sprod[WIDTH-1:0];
            end
            MDU_MULTU: begin
                hi_res = uprod[2*WIDTH-1:WIDTH];
                lo_res = uprod[WIDTH-1:0];
            end
            MDU_DIV: begin
                hi_res = sr;
                lo_res = sq;
            end
            MDU_DIVU: begin
                hi_res = ur;
                lo_res = uq;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle HI/LO multiply/divide unit: FSM, latency counter and result registers.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_res, lo_res;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_res),
        .lo_res (lo_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_DIV;
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q - 1'b1;
                // Final count: commit result; a zero divisor keeps HI/LO as they were.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!(state_q == ST_DIV && b_q == '0)) begin
                        hi_d = hi_res;
                        lo_d = lo_res;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: cycle-level reference model plus literal result checks.
module tb_mdu_unit;

    localparam int NMUL = 5;
    localparam int NDIV = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mdu_unit #(.WIDTH(32), .MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: architectural HI/LO, cycles left in flight, pending result.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_rem = 0;
    bit          p_wr = 0;
    bit          m_done = 0;
    int          busy_n, done_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_rem = 0; p_wr = 0; m_done = 0;
    endtask

    task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] av, bv);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        m_done = 0;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                if (p_wr) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                m_done = 1;
            end
        end else if (s) begin
            p_wr = 1;
            case (o)
                3'd0: begin
                    sp = longint'($signed(av)) * longint'($signed(bv));
                    p_hi = sp[63:32]; p_lo = sp[31:0]; m_rem = NMUL;
                end
                3'd1: begin
                    up = {32'h0, av} * {32'h0, bv};
                    p_hi = up[63:32]; p_lo = up[31:0]; m_rem = NMUL;
                end
                3'd2: begin
                    sa = $signed(av); sb = $signed(bv); m_rem = NDIV;
                    if (sb == 0) p_wr = 0;
                    else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                        p_lo = 32'h8000_0000; p_hi = 32'h0;
                    end else begin
                        p_lo = sa / sb; p_hi = sa % sb;
                    end
                end
                3'd3: begin
                    m_rem = NDIV;
                    if (bv == 0) p_wr = 0;
                    else begin
                        p_lo = av / bv; p_hi = av % bv;
                    end
                end
                3'd4: m_hi = av;
                3'd5: m_lo = av;
                default: ;
            endcase
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
    task automatic step(input logic s, input logic [2:0] o, input logic [31:0] av, bv);
        start = s; op = o; a = av; b = bv;
        @(posedge clk);
        model_edge(s, o, av, bv);
        #1;
        check("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
        check("done", {31'b0, done}, {31'b0, m_done});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (busy) busy_n++;
        if (done) done_n++;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] av, bv);
        busy_n = 0;
        done_n = 0;
        step(1'b1, o, av, bv);
    endtask

    // Idle cycles with scrambled operands; optionally a competing start at index inj_at.
    task automatic run_window(input int n, input int inj_at, input logic [2:0] io, input logic [31:0] ia);
        for (int i = 0; i < n; i++) begin
            if (i == inj_at) step(1'b1, io, ia, 32'h0);
            else step(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst_n = 1'b1;

        // Signed multiply: -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        run_window(7, -1, 3'd0, 32'h0);
        check("mult_busy_cycles", busy_n, NMUL);
        check("mult_done_pulses", done_n, 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // Signed and unsigned divide of 0xFFFFFFF9 by 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_window(12, -1, 3'd0, 32'h0);
        check("div_busy_cycles", busy_n, NDIV);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_window(12, -1, 3'd0, 32'h0);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'h0000_0001);

        // MTHI then DIVU by zero
        issue(3'd4, 32'h1234_5678, 32'h0);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        issue(3'd3, 32'd99, 32'd0);
        run_window(12, -1, 3'd0, 32'h0);
        check("div0_busy_cycles", busy_n, NDIV);
        check("div0_done_pulses", done_n, 1);
        check("div0_hi", hi, 32'h1234_5678);
        check("div0_lo", lo, 32'h7FFF_FFFC);

        // MULTU with an MTLO attempted while busy
        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        run_window(7, 1, 3'd5, 32'h0000_00AA);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'h0000_0000);
        check("multu_done_pulses", done_n, 1);

        // Asynchronous reset in the middle of a DIV
        issue(3'd2, 32'd100, 32'd7);
        run_window(2, -1, 3'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        #1;
        rst_n = 1'b1;
        busy_n = 0;
        done_n = 0;
        run_window(14, -1, 3'd0, 32'h0);
        check("abort_no_done", done_n, 0);

        // Signed overflow, then MULT issued the cycle after done
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_window(NDIV, -1, 3'd0, 32'h0);
        check("ovf_done_now", {31'b0, done}, 32'd1);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_window(6, -1, 3'd0, 32'h0);
        check("b2b_busy_cycles", busy_n, NMUL);
        check("b2b_done_pulses", done_n, 1);
        check("b2b_hi", hi, 32'hFFFF_FFFF);
        check("b2b_lo", lo, 32'hFFFF_FFEB);

        // Reserved op must be ignored
        issue(3'd6, 32'h5555_5555, 32'h1);
        run_window(3, -1, 3'd0, 32'h0);
        check("rsvd_busy_cycles", busy_n, 0);
        check("rsvd_lo", lo, 32'hFFFF_FFEB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
